// File: rtl/ysyx_2022040010_iter_add.sv
// Multi-cycle integer adder/subtractor for the EXU.
// Sums CHUNK bits per cycle through a registered carry so the carry chain
// stays short. Supports RV64 word ops (32-bit, sign-extended result),
// subtraction, a carry-out flag and a signed-overflow flag. Both sides use
// valid/ready handshakes. CHUNK must divide XLEN/2 exactly.
module ysyx_2022040010_iter_add #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_sub,
    input  logic            in_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_s,
    output logic            out_c,
    output logic            out_ov
);

    localparam int NCH = XLEN / CHUNK;   // chunks in a full-width op
    localparam int CW  = $clog2(NCH);    // chunk counter width

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                    r_state;
    logic [NCH-1:0][CHUNK-1:0] r_a;
    logic [NCH-1:0][CHUNK-1:0] r_b;      // already inverted for subtraction
    logic [NCH-1:0][CHUNK-1:0] r_res;    // partial result, then formatted result
    logic                      r_carry;
    logic                      r_word;
    logic [CW-1:0]             r_cnt;
    logic                      r_c;
    logic                      r_ov;

    logic [CHUNK-1:0]          w_a_chk;
    logic [CHUNK-1:0]          w_b_chk;
    logic [CHUNK:0]            w_sum;
    logic [NCH-1:0][CHUNK-1:0] w_res_nxt;
    logic [XLEN-1:0]           w_res_flat;
    logic [XLEN-1:0]           w_fmt;
    logic                      w_ov;
    logic [CW-1:0]             w_last_idx;
    logic                      w_last;
    logic [XLEN-1:0]           w_b_inv;

    // Handshake flags decode straight from the state register, so there is
    // no combinational path from any input to them.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_s     = r_res;
    assign out_c     = r_c;
    assign out_ov    = r_ov;

    // Word mode stops halfway: the carry out of bit 31 is the final carry.
    assign w_last_idx = r_word ? CW'(NCH / 2 - 1) : CW'(NCH - 1);
    assign w_last     = (r_cnt == w_last_idx);
    assign w_b_inv    = in_sub ? ~in_b : in_b;

    // One chunk of the sum, its merge into the result, and final formatting.
    always_comb begin
        w_a_chk           = r_a[r_cnt];
        w_b_chk           = r_b[r_cnt];
        w_sum             = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
        w_res_nxt         = r_res;
        w_res_nxt[r_cnt]  = w_sum[CHUNK-1:0];
        w_res_flat        = w_res_nxt;
        w_fmt             = r_word ? {{(XLEN-32){w_res_flat[31]}}, w_res_flat[31:0]}
                                   : w_res_flat;
        // Overflow: both operand signs equal and the result sign differs.
        w_ov              = (w_a_chk[CHUNK-1] == w_b_chk[CHUNK-1]) &&
                            (w_sum[CHUNK-1]   != w_a_chk[CHUNK-1]);
    end

    // Control FSM with operand latch, per-chunk accumulation and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_word  <= 1'b0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_ov    <= 1'b0;
        end else if (flush) begin
            // Abort wins over any handshake; data registers may stay stale.
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Upper halves are zeroed in word mode so they can
                        // never reach any output.
                        r_a     <= in_word ? {{(XLEN-32){1'b0}}, in_a[31:0]} : in_a;
                        r_b     <= in_word ? {{(XLEN-32){1'b0}}, w_b_inv[31:0]} : w_b_inv;
                        r_carry <= in_sub;
                        r_word  <= in_word;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res   <= w_fmt;
                        r_c     <= w_sum[CHUNK];
                        r_ov    <= w_ov;
                        r_state <= S_DONE;
                    end else begin
                        r_res   <= w_res_nxt;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_iter_add.sv
// Directed self-checking bench for ysyx_2022040010_iter_add.
module tb_ysyx_2022040010_iter_add;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic            in_sub;
    logic            in_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_s;
    logic            out_c;
    logic            out_ov;

    int checks   = 0;
    int failures = 0;

    ysyx_2022040010_iter_add #(.XLEN(XLEN), .CHUNK(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_ov    (out_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set for a single edge (caller sits #1 after an edge).
    task automatic accept(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic sub, input logic word);
        in_a = a; in_b = b; in_sub = sub; in_word = word; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_word = 1'b0;
    endtask

    // Count edges after acceptance until out_valid; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    // Full transaction with out_ready high; captures the result and lets the
    // output handshake complete.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic sub, input logic word, output int lat,
                          output logic [XLEN-1:0] s, output logic c, output logic ov);
        out_ready = 1'b1;
        accept(a, b, sub, word);
        wait_valid(lat);
        s = out_s; c = out_c; ov = out_ov;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_s !== 64'd0 ||
            out_c !== 1'b0 || out_ov !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_s=%h c=%b ov=%b, want 1 0 0 0 0",
                     in_ready, out_valid, out_s, out_c, out_ov);
        end
    endtask

    task automatic test_add64;
        int lat; logic [XLEN-1:0] s; logic c, ov;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, s, c, ov);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL add64_latency: got %0d want 4", lat); end
        checks++;
        if (s !== 64'd0 || c !== 1'b1 || ov !== 1'b0) begin
            failures++;
            $display("FAIL add64_result: s=%h c=%b ov=%b want 0 1 0", s, c, ov);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add64_return_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_word_add;
        int lat; logic [XLEN-1:0] s; logic c, ov;
        run_op(64'h1234_5678_7FFF_FFFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, lat, s, c, ov);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL word_add_latency: got %0d want 2", lat); end
        checks++;
        if (s !== 64'hFFFF_FFFF_8000_0000 || c !== 1'b0 || ov !== 1'b1) begin
            failures++;
            $display("FAIL word_add_result: s=%h c=%b ov=%b want ffffffff80000000 0 1", s, c, ov);
        end
    endtask

    task automatic test_sub;
        int lat; logic [XLEN-1:0] s; logic c, ov;
        run_op(64'h0000_0000_8000_0000, 64'd1, 1'b1, 1'b1, lat, s, c, ov);
        checks++;
        if (s !== 64'h0000_0000_7FFF_FFFF || c !== 1'b1 || ov !== 1'b1) begin
            failures++;
            $display("FAIL word_sub_result: s=%h c=%b ov=%b want 000000007fffffff 1 1", s, c, ov);
        end
        run_op(64'd3, 64'd5, 1'b1, 1'b0, lat, s, c, ov);
        checks++;
        if (lat !== 4 || s !== 64'hFFFF_FFFF_FFFF_FFFE || c !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL sub64_result: lat=%0d s=%h c=%b ov=%b want 4 fffffffffffffffe 0 0",
                     lat, s, c, ov);
        end
    endtask

    task automatic test_backpressure;
        int lat; int bad;
        out_ready = 1'b0;
        accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (lat !== 4 || out_s !== 64'h8000_0000_0000_0000 || out_c !== 1'b0 || out_ov !== 1'b1) begin
            failures++;
            $display("FAIL bp_result: lat=%0d s=%h c=%b ov=%b want 4 8000000000000000 0 1",
                     lat, out_s, out_c, out_ov);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_s !== 64'h8000_0000_0000_0000 ||
                out_c !== 1'b0 || out_ov !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 6 stalled cycles changed, want 0", bad);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush;
        int lat; int seen; logic [XLEN-1:0] s; logic c, ov;
        out_ready = 1'b1;
        accept(64'd100, 64'd200, 1'b0, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL flush_no_valid: out_valid seen %0d cycles want 0", seen); end
        run_op(64'd10, 64'd20, 1'b0, 1'b0, lat, s, c, ov);
        checks++;
        if (lat !== 4 || s !== 64'd30 || c !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL flush_next_op: lat=%0d s=%h c=%b ov=%b want 4 1e 0 0", lat, s, c, ov);
        end
    endtask

    task automatic test_async_reset;
        int lat; logic [XLEN-1:0] s; logic c, ov;
        out_ready = 1'b1;
        accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_s !== 64'd0 || out_c !== 1'b0 || out_ov !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy: in_ready=%b out_valid=%b s=%h c=%b ov=%b want 1 0 0 0 0",
                     in_ready, out_valid, out_s, out_c, out_ov);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 1'b0, 1'b0);
        wait_valid(lat);
        checks++;
        if (out_valid !== 1'b1 || out_s !== 64'h8000_0000_0000_0004 || out_ov !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_done: valid=%b s=%h ov=%b want 1 8000000000000004 1",
                     out_valid, out_s, out_ov);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_s !== 64'd0 || out_c !== 1'b0 || out_ov !== 1'b0) begin
            failures++;
            $display("FAIL rst_done: in_ready=%b out_valid=%b s=%h c=%b ov=%b want 1 0 0 0 0",
                     in_ready, out_valid, out_s, out_c, out_ov);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat, s, c, ov);
        checks++;
        if (lat !== 4 || s !== 64'h2345_6789_ABCD_F001 || c !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d s=%h c=%b ov=%b want 4 23456789abcdf001 0 0", lat, s, c, ov);
        end
        run_op(64'hAAAA_AAAA_0000_0005, 64'h5555_5555_0000_0007, 1'b1, 1'b1, lat, s, c, ov);
        checks++;
        if (lat !== 2 || s !== 64'hFFFF_FFFF_FFFF_FFFE || c !== 1'b0 || ov !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d s=%h c=%b ov=%b want 2 fffffffffffffffe 0 0", lat, s, c, ov);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_word = 1'b0;
        #12;
        test_reset;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_add64;
        test_word_add;
        test_sub;
        test_backpressure;
        test_flush;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_2022040010_iter_add.md
Name: ysyx_2022040010_iter_add

Overview:
- Parametrised, multi-cycle integer adder/subtractor for the EXU.
- Adds CHUNK bits per cycle through a registered carry, so the chain is short and timing closes at higher frequency.
- Supports RV64 word mode (32-bit op, sign-extended result), subtraction, carry-out and signed-overflow flags.
- Input and output use valid/ready handshakes, so the EXU can stall either side.

Parameters:
- XLEN, 64, operand/result width.
- CHUNK, 16, bits summed per cycle. Must divide XLEN/2 exactly; non-dividing values are illegal.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_a  input  XLEN  operand A.
- in_b  input  XLEN  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- in_word  input  1  1 = 32-bit operation (RV64 *W).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_s  output  XLEN  sum/difference.
- out_c  output  1  carry out of MSB of active width. For sub this is no-borrow (1 when A >= B unsigned).
- out_ov  output  1  signed overflow of active width.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, out_s = 0, out_c = 0, out_ov = 0.
  - Carry, chunk counter and operand registers cleared.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE to BUSY on in_valid && in_ready.
  - Latch A.
  - Latch B' = in_sub ? ~in_b : in_b.
  - Set carry = in_sub, word flag = in_word, counter = 0.
  - In word mode, only bits [31:0] of the operands are used.
- BUSY:
  - Each cycle, sum chunk k (bits [k*CHUNK +: CHUNK]) with the registered carry.
  - Write the chunk into the result register, update the carry, increment k.
  - N = (word ? 32 : XLEN) / CHUNK cycles.
  - After the last chunk, go to DONE.
- Latency:
  - Operands accepted at edge T; out_valid rises after edge T+N.
  - Defaults: 4 cycles for 64-bit, 2 cycles for word.
- DONE:
  - out_s, out_c and out_ov are registered and held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE. New operands are accepted no earlier than the following cycle.
- Result formatting:
  - 64-bit mode: out_s = result[XLEN-1:0].
  - Word mode: out_s = sign-extension of result[31:0].
  - out_c = final carry out of bit 31 (word mode) or bit XLEN-1.
  - out_ov = carry-into-MSB XOR carry-out-of-MSB of the active width. Equivalently, operand signs equal (after B inversion) and result sign differs.
- Upper-half garbage: in word mode, in_a/in_b bits [63:32] never affect any output.
- Flush:
  - flush high at an edge forces state to IDLE from any state and drops out_valid.
  - flush overrides a simultaneous input or output handshake, so the transaction is lost.
  - Output data registers may keep stale values.
- Reset mid-operation: the in-flight result is discarded and outputs return to reset values immediately.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Test Plan:
- 64-bit add, A=0xFFFF_FFFF_FFFF_FFFF, B=1, out_ready=1 -> out_valid 4 cycles after accept; out_s=0, out_c=1, out_ov=0.
- Word add, A=0x1234_5678_7FFF_FFFF, B=0xDEAD_BEEF_0000_0001 -> after 2 cycles: out_s=0xFFFF_FFFF_8000_0000, out_c=0, out_ov=1 (upper halves ignored).
- Word sub, A=0x8000_0000, B=1 -> out_s=0x0000_0000_7FFF_FFFF, out_c=1, out_ov=1. 64-bit sub, A=3, B=5 -> out_s=0xFFFF_FFFF_FFFF_FFFE, out_c=0, out_ov=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid=1 and out_s/out_c/out_ov constant, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
- Flush after 2 BUSY cycles of a 64-bit op -> next cycle in_ready=1, out_valid never asserts. A following op A=10, B=20 yields out_s=30 with correct 4-cycle latency.
- Assert rst_n=0 asynchronously mid-BUSY, then in DONE with out_valid=1 -> outputs reach reset values without a clock edge. After release, back-to-back ops complete correctly.
